// File: rtl/march_bist.sv
// march_bist: March-algorithm memory BIST controller driving a synchronous-read
// RAM (1-cycle read latency) through a dedicated test port.
//
// Ports:
//   clk, rst (async, active-high)
//   start, mode        : start test; mode 0 = MATS+, 1 = March C- (latched at start)
//   mem_addr/we/wdata  : RAM test port (registered)
//   mem_rdata          : RAM read data, valid the cycle after the read address
//   busy, done, status : run flag, completion flag (held), 1 = pass
//   fail_addr/elem     : location of the first miscompare of the run
//   err_cnt            : saturating miscompare count
//
// Optional feature: define MARCH_BIST_CKBD_EN to repeat the whole algorithm
// once more with a checkerboard background; fail_elem[2] flags that pass.
//
// state    | meaning
// IDLE     | waiting for start
// WR       | write op on the RAM port
// RD_ISSUE | read address on the RAM port
// RD_CMP   | read data compared against expected background
// NEXT     | combinational op/address/element sequencing (never registered)
// DONE     | finished, done held, start accepted as in IDLE
module march_bist #(
  parameter int ADR_SIZE  = 4,
  parameter int DATA_SIZE = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  output logic [ADR_SIZE-1:0]  mem_addr,
  output logic                 mem_we,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 status,
  output logic [ADR_SIZE-1:0]  fail_addr,
  output logic [2:0]           fail_elem,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CMP, NEXT, DONE} state_t;

  state_t              state;
  logic                mode_q;
  logic [2:0]          elem;
  logic                op;
  logic [ADR_SIZE-1:0] addr;
  logic                pass;

  function automatic logic [DATA_SIZE-1:0] ckbd_pat();
    logic [DATA_SIZE-1:0] p;
    for (int i = 0; i < DATA_SIZE; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [DATA_SIZE-1:0] CKBD = ckbd_pat();

  // Background word for logical value v at an address with LSB a0.
  function automatic logic [DATA_SIZE-1:0] bg(input logic v, input logic a0, input logic p);
    logic [DATA_SIZE-1:0] d;
    d = {DATA_SIZE{v}};
    if (p) d = d ^ CKBD ^ {DATA_SIZE{a0}};
    return d;
  endfunction

  // Element table shared by both algorithms: e0 = w0, e5 = r0, and every
  // element in between is a read of v followed by a write of ~v, v = ~e[0].
  function automatic logic two_op(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic is_read(input logic [2:0] e, input logic o);
    return (e == 3'd5) || ((e != 3'd0) && !o);
  endfunction

  function automatic logic op_val(input logic [2:0] e, input logic o);
    return two_op(e) ? (o ? e[0] : ~e[0]) : 1'b0;
  endfunction

  function automatic logic is_down(input logic m, input logic [2:0] e);
    return m ? ((e == 3'd3) || (e == 3'd4)) : (e == 3'd2);
  endfunction

  function automatic logic [2:0] last_elem(input logic m);
    return m ? 3'd5 : 3'd2;
  endfunction

  logic [2:0]           n_elem;
  logic                 n_op;
  logic [ADR_SIZE-1:0]  n_addr;
  logic                 n_pass;
  logic                 seq_done;
  logic                 n_read;
  logic [DATA_SIZE-1:0] n_data;
  logic [DATA_SIZE-1:0] exp_data;
  logic                 miscmp;
  logic                 down;

  // NEXT: advance op, then address, then element (then pass).
  always_comb begin
    n_elem   = elem;
    n_op     = op;
    n_addr   = addr;
    n_pass   = pass;
    seq_done = 1'b0;
    down     = is_down(mode_q, elem);
    if (two_op(elem) && !op) begin
      n_op = 1'b1;
    end else begin
      n_op = 1'b0;
      if (addr != (down ? '0 : '1)) begin
        n_addr = down ? addr - 1'b1 : addr + 1'b1;
      end else if (elem != last_elem(mode_q)) begin
        n_elem = elem + 3'd1;
        n_addr = is_down(mode_q, elem + 3'd1) ? '1 : '0;
      end else begin
`ifdef MARCH_BIST_CKBD_EN
        if (!pass) begin
          n_pass = 1'b1;
          n_elem = 3'd0;
          n_addr = '0;
        end else begin
          seq_done = 1'b1;
        end
`else
        seq_done = 1'b1;
`endif
      end
    end
    n_read   = is_read(n_elem, n_op);
    n_data   = bg(op_val(n_elem, n_op), n_addr[0], n_pass);
    exp_data = bg(op_val(elem, op), addr[0], pass);
    miscmp   = (mem_rdata != exp_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      elem      <= 3'd0;
      op        <= 1'b0;
      addr      <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= 1'b1;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      err_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WR;
            mode_q    <= mode;
            elem      <= 3'd0;
            op        <= 1'b0;
            addr      <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            status    <= 1'b1;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            err_cnt   <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        RD_ISSUE: state <= RD_CMP;
        WR, RD_CMP: begin
          if (state == RD_CMP && miscmp) begin
            status <= 1'b0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            // status still high means this is the first miscompare of the run
            if (status) begin
              fail_addr <= addr;
              fail_elem <= elem | {pass, 2'b00};
            end
          end
          if (seq_done) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            mem_we <= 1'b0;
          end else begin
            state     <= n_read ? RD_ISSUE : WR;
            elem      <= n_elem;
            op        <= n_op;
            addr      <= n_addr;
            pass      <= n_pass;
            mem_we    <= ~n_read;
            mem_addr  <= n_addr;
            mem_wdata <= n_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist.sv
module tb_march_bist;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, status;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  march_bist #(.ADR_SIZE(AW), .DATA_SIZE(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .status(status),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // RAM with optional stuck-at bit and read-data override
  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_q;
  logic          fault_en = 1'b0;
  logic [AW-1:0] f_addr = '0;
  int            f_bit = 0;
  logic          f_val = 1'b0;
  logic          ovr = 1'b0;

  function automatic logic [DW-1:0] stuck(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fault_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= stuck(mem_addr, mem_wdata);
    ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ovr ? '1 : ram_q;

  // Reference model: algorithms as element strings (direction, then op pairs)
  string mats[3] = '{"Uw0", "Ur0w1", "Dr1w0"};
  string cmin[6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};

  logic          exp_we[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_wd[$];
  logic [DW-1:0] exp_ram [N];
  int exp_cyc, exp_errs, exp_faddr, exp_felem;

  logic          got_we[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_wd[$];
  int got_cyc;

  function automatic logic [DW-1:0] bgv(input logic v, input int a, input int p);
    logic [DW-1:0] pat;
    if (p == 0) return {DW{v}};
    pat = 8'h55;
    return pat ^ {DW{a[0]}} ^ {DW{v}};
  endfunction

  task automatic model(input logic m);
    logic [DW-1:0] mr [N];
    string s;
    int nel, passes, a;
    logic v;
    logic [DW-1:0] d;
    bit first;
    exp_we.delete(); exp_addr.delete(); exp_wd.delete();
    exp_cyc = 0; exp_errs = 0; exp_faddr = 0; exp_felem = 0;
    first = 1;
    for (int i = 0; i < N; i++) mr[i] = '0;
    nel = m ? 6 : 3;
`ifdef MARCH_BIST_CKBD_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int p = 0; p < passes; p++)
      for (int e = 0; e < nel; e++) begin
        s = m ? cmin[e] : mats[e];
        for (int k = 0; k < N; k++) begin
          a = (s[0] == "U") ? k : N - 1 - k;
          for (int j = 1; j + 1 < s.len(); j += 2) begin
            v = (s[j+1] == "1");
            d = bgv(v, a, p);
            if (s[j] == "r") begin
              repeat (2) begin
                exp_we.push_back(1'b0); exp_addr.push_back(a[AW-1:0]); exp_wd.push_back(d);
              end
              exp_cyc += 2;
              if (mr[a] !== d) begin
                if (exp_errs < 255) exp_errs++;
                if (first) begin exp_faddr = a; exp_felem = e | (p << 2); first = 0; end
              end
            end else begin
              exp_we.push_back(1'b1); exp_addr.push_back(a[AW-1:0]); exp_wd.push_back(d);
              exp_cyc += 1;
              mr[a] = stuck(a[AW-1:0], d);
            end
          end
        end
      end
    for (int i = 0; i < N; i++) exp_ram[i] = mr[i];
  endtask

  function automatic int trace_err();
    int e;
    e = 0;
    if (got_we.size() != exp_we.size()) return 1000;
    for (int i = 0; i < got_we.size(); i++)
      if (got_we[i] !== exp_we[i] || got_addr[i] !== exp_addr[i] ||
          (exp_we[i] && got_wd[i] !== exp_wd[i])) e++;
    return e;
  endfunction

  function automatic int ram_err();
    int e;
    e = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== exp_ram[i]) e++;
    return e;
  endfunction

  // Start a run and follow it to completion, recording the RAM-port trace.
  task automatic run(input logic m, input int ovr_lo, input int ovr_hi, input int mid_start);
    got_we.delete(); got_addr.delete(); got_wd.delete();
    got_cyc = 0;
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0; mode = ~m;
    while (busy && got_cyc < 2000) begin
      ovr   = (got_cyc >= ovr_lo && got_cyc <= ovr_hi);
      start = (got_cyc == mid_start);
      got_we.push_back(mem_we); got_addr.push_back(mem_addr); got_wd.push_back(mem_wdata);
      got_cyc++;
      @(negedge clk);
    end
    ovr = 1'b0; start = 1'b0;
    if (got_cyc >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout busy still high after %0d cycles", got_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (status !== 1'b1)  begin n_err++; $display("FAIL reset_status got=%b exp=1", status); end
    n_cmp++; if (err_cnt !== '0)   begin n_err++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    n_cmp++; if (mem_we !== 1'b0)  begin n_err++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0 || fail_addr !== '0 || fail_elem !== 3'd0) begin
      n_err++; $display("FAIL reset_regs got addr=%0h wdata=%0h faddr=%0h felem=%0d exp all 0",
                        mem_addr, mem_wdata, fail_addr, fail_elem);
    end
  endtask

  task automatic test_clean(input logic m);
    fault_en = 1'b0;
    model(m);
    run(m, -1, -1, -1);
    n_cmp++; if (got_cyc !== exp_cyc) begin n_err++; $display("FAIL clean_cycles m=%0d got=%0d exp=%0d", m, got_cyc, exp_cyc); end
    n_cmp++; if (done !== 1'b1 || status !== 1'b1 || err_cnt !== '0) begin
      n_err++; $display("FAIL clean_result m=%0d got done=%b status=%b err=%0d exp 1 1 0", m, done, status, err_cnt);
    end
    n_cmp++; if (trace_err() !== 0) begin n_err++; $display("FAIL clean_trace m=%0d got %0d bad entries exp 0", m, trace_err()); end
    n_cmp++; if (ram_err() !== 0) begin n_err++; $display("FAIL clean_ram m=%0d got %0d bad words exp 0", m, ram_err()); end
    repeat (4) @(negedge clk);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL done_hold got done=%b busy=%b exp 1 0", done, busy); end
  endtask

  task automatic test_rdata_override();
    fault_en = 1'b0;
    model(1'b1);
    // cycles 15..18: last e0 write, then e1 read of address 0 and its write
    run(1'b1, 15, 18, -1);
    n_cmp++; if (got_cyc !== 240) begin n_err++; $display("FAIL ovr_cycles got=%0d exp=240", got_cyc); end
    n_cmp++; if (status !== 1'b0 || fail_elem !== 3'd1 || fail_addr !== '0) begin
      n_err++; $display("FAIL ovr_fail got status=%b elem=%0d addr=%0d exp 0 1 0", status, fail_elem, fail_addr);
    end
    n_cmp++; if (err_cnt < 1 || done !== 1'b1) begin n_err++; $display("FAIL ovr_errcnt got err=%0d done=%b exp >=1 1", err_cnt, done); end
  endtask

  task automatic test_stuck_mats();
    fault_en = 1'b1; f_addr = 4'd5; f_bit = 3; f_val = 1'b0;
    for (int r = 0; r < 2; r++) begin
      run(1'b0, -1, -1, (r == 0) ? 40 : -1);
      n_cmp++; if (got_cyc !== 112) begin n_err++; $display("FAIL stuck_cycles run=%0d got=%0d exp=112", r, got_cyc); end
      n_cmp++; if (status !== 1'b0 || fail_elem !== 3'd2 || fail_addr !== 4'd5 || err_cnt !== 8'd1) begin
        n_err++; $display("FAIL stuck_report run=%0d got status=%b elem=%0d addr=%0d err=%0d exp 0 2 5 1",
                          r, status, fail_elem, fail_addr, err_cnt);
      end
    end
    fault_en = 1'b0;
  endtask

  task automatic test_random();
    logic m;
    for (int it = 0; it < 6; it++) begin
      m = $urandom_range(0, 1);
      fault_en = $urandom_range(0, 3) != 0;
      f_addr = $urandom_range(0, N - 1);
      f_bit = $urandom_range(0, DW - 1);
      f_val = $urandom_range(0, 1);
      model(m);
      run(m, -1, -1, $urandom_range(5, 60));
      n_cmp++; if (got_cyc !== exp_cyc || trace_err() !== 0) begin
        n_err++; $display("FAIL rand_trace it=%0d got cyc=%0d bad=%0d exp cyc=%0d bad=0", it, got_cyc, trace_err(), exp_cyc);
      end
      n_cmp++; if (err_cnt !== exp_errs[CW-1:0] || status !== (exp_errs == 0)) begin
        n_err++; $display("FAIL rand_errs it=%0d got err=%0d status=%b exp err=%0d", it, err_cnt, status, exp_errs);
      end
      n_cmp++; if (exp_errs != 0 && (fail_addr !== exp_faddr[AW-1:0] || fail_elem !== exp_felem[2:0])) begin
        n_err++; $display("FAIL rand_first it=%0d got addr=%0d elem=%0d exp addr=%0d elem=%0d",
                          it, fail_addr, fail_elem, exp_faddr, exp_felem);
      end
      n_cmp++; if (ram_err() !== 0) begin n_err++; $display("FAIL rand_ram it=%0d got %0d bad words exp 0", it, ram_err()); end
    end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int c;
    c = 0;
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy && c < 50) begin c++; @(negedge clk); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || status !== 1'b1 || err_cnt !== '0) begin
      n_err++; $display("FAIL midrst_flags got busy=%b done=%b status=%b err=%0d exp 0 0 1 0", busy, done, status, err_cnt);
    end
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || fail_addr !== '0 || fail_elem !== 3'd0) begin
      n_err++; $display("FAIL midrst_regs got we=%b addr=%0h wdata=%0h faddr=%0h felem=%0d exp all 0",
                        mem_we, mem_addr, mem_wdata, fail_addr, fail_elem);
    end
    @(negedge clk); rst = 1'b0;
    run(1'b0, -1, -1, -1);
    n_cmp++; if (got_cyc !== 112 || status !== 1'b1 || done !== 1'b1) begin
      n_err++; $display("FAIL midrst_rerun got cyc=%0d status=%b done=%b exp 112 1 1", got_cyc, status, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    test_reset();
    test_clean(1'b0);
    test_clean(1'b1);
    test_rdata_override();
    test_stuck_mats();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
